tex_dcr_bank: RTL and testbench

// - Texture-unit DCR store, upstream of the sampler address stage. It captures device-config-register writes into
//   per-stage texture state and serves it to the pipeline.
// - The pipeline presents a stage index. The block returns the full packed tex_dcrs_t for that stage through a

---
 rtl/VX_tex_types.sv | 61 ++++++
 rtl/tex_dcr_bank_if.sv | 35 +++
 rtl/tex_dcr_decode.sv | 79 +++++++
 rtl/tex_dcr_bank.sv | 109 ++++++++++
 tb/tb_tex_dcr_bank.sv | 376 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/VX_tex_types.sv
`default_nettype none
// ============================================================================
// Module   : VX_tex_types (package)
// Brief    : Shared texture-unit widths, DCR window offsets, and per-stage state type.
// Revision : 1.0  initial release
// ============================================================================
package VX_tex_types;

  localparam int unsigned TEX_ADDR_BITS   = 28;
  localparam int unsigned TEX_LOD_BITS    = 4;
  localparam int unsigned TEX_LOD_MAX     = 11;
  localparam int unsigned TEX_NUM_LODS    = TEX_LOD_MAX + 1;
  localparam int unsigned TEX_MIPOFF_BITS = 20;
  localparam int unsigned TEX_FORMAT_BITS = 3;
  localparam int unsigned TEX_WRAP_BITS   = 2;

  localparam int unsigned TEX_DCR_STAGE  = 0;
  localparam int unsigned TEX_DCR_ADDR   = 1;
  localparam int unsigned TEX_DCR_LOGDIM = 2;
  localparam int unsigned TEX_DCR_FORMAT = 3;
  localparam int unsigned TEX_DCR_FILTER = 4;
  localparam int unsigned TEX_DCR_WRAP   = 5;
  localparam int unsigned TEX_DCR_MIPOFF = 6;
  localparam int unsigned TEX_DCR_COMMIT = 7 + TEX_LOD_MAX;

  // Bit positions in the field-write-enable vector; mipoff gets one bit per LOD.
  localparam int unsigned TEX_FWE_ADDR   = 0;
  localparam int unsigned TEX_FWE_LOGDIM = 1;
  localparam int unsigned TEX_FWE_FORMAT = 2;
  localparam int unsigned TEX_FWE_FILTER = 3;
  localparam int unsigned TEX_FWE_WRAP   = 4;
  localparam int unsigned TEX_FWE_MIPOFF = 5;
  localparam int unsigned TEX_FWE_W      = TEX_FWE_MIPOFF + TEX_NUM_LODS;

  typedef logic [TEX_FWE_W-1:0] tex_fwe_t;

  typedef struct packed {
    logic [TEX_NUM_LODS-1:0][TEX_MIPOFF_BITS-1:0] mipoff;
    logic [1:0][TEX_WRAP_BITS-1:0]                wraps;    // [0]=u, [1]=v
    logic [1:0][TEX_LOD_BITS-1:0]                 logdims;  // [0]=u, [1]=v
    logic                                         filter;
    logic [TEX_FORMAT_BITS-1:0]                   format;
    logic [TEX_ADDR_BITS-1:0]                     baseaddr;
  } tex_dcrs_t;

  function automatic tex_dcrs_t tex_dcr_merge(tex_dcrs_t cur, tex_dcrs_t img, tex_fwe_t we);
    tex_dcrs_t r;
    r = cur;
    if (we[TEX_FWE_ADDR])   r.baseaddr = img.baseaddr;
    if (we[TEX_FWE_LOGDIM]) r.logdims  = img.logdims;
    if (we[TEX_FWE_FORMAT]) r.format   = img.format;
    if (we[TEX_FWE_FILTER]) r.filter   = img.filter;
    if (we[TEX_FWE_WRAP])   r.wraps    = img.wraps;
    for (int l = 0; l < int'(TEX_NUM_LODS); l++) begin
      if (we[TEX_FWE_MIPOFF + l]) r.mipoff[l] = img.mipoff[l];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tex_dcr_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : tex_dcr_bank_if
// Brief    : DCR write bus plus stage-lookup request/response handshake.
// Revision : 1.0  initial release
// ============================================================================
interface tex_dcr_bank_if
  import VX_tex_types::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned STAGE_W = 1
);
  logic               dcr_wr_valid;
  logic [ADDR_W-1:0]  dcr_wr_addr;
  logic [31:0]        dcr_wr_data;
  logic               req_valid;
  logic [STAGE_W-1:0] req_stage;
  logic               req_ready;
  logic               rsp_valid;
  tex_dcrs_t          rsp_dcrs;
  logic               rsp_ready;

  modport master (
    output dcr_wr_valid, dcr_wr_addr, dcr_wr_data,
    output req_valid, req_stage, input req_ready,
    input  rsp_valid, rsp_dcrs, output rsp_ready
  );

  modport slave (
    input  dcr_wr_valid, dcr_wr_addr, dcr_wr_data,
    input  req_valid, req_stage, output req_ready,
    output rsp_valid, rsp_dcrs, input rsp_ready
  );
endinterface
`default_nettype wire

// File: rtl/tex_dcr_decode.sv
`default_nettype none
// ============================================================================
// Module   : tex_dcr_decode
// Brief    : Maps a DCR write onto stage-select, field-write enables and a formatted field image.
//            Macro TEX_DCR_SHADOW_EN adds the commit strobe.
// Revision : 1.0  initial release
// ============================================================================
module tex_dcr_decode
  import VX_tex_types::*;
#(
  parameter int unsigned      NUM_STAGES = 2,
  parameter int unsigned      STAGE_W    = 1,
  parameter int unsigned      ADDR_W     = 12,
  parameter logic [ADDR_W-1:0] DCR_BASE  = '0
) (
  input  logic               wr_valid,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [31:0]        wr_data,
  output logic               stage_we,
  output logic [STAGE_W-1:0] stage_val,
  output tex_fwe_t           field_we,
`ifdef TEX_DCR_SHADOW_EN
  output logic               commit,
`endif
  output tex_dcrs_t          img
);

  logic [ADDR_W-1:0] w_off;
  logic              w_below;
  logic [31:0]       w_off32;
  logic              w_hit;

  // The borrow out of the subtraction flags addresses below the window base.
  assign {w_below, w_off} = {1'b0, wr_addr} - {1'b0, DCR_BASE};
  assign w_off32 = 32'(w_off);
  assign w_hit   = wr_valid && !w_below;

  always_comb begin
    stage_we   = 1'b0;
    stage_val  = '0;
    field_we   = '0;
`ifdef TEX_DCR_SHADOW_EN
    commit     = 1'b0;
`endif
    img            = '0;
    img.baseaddr   = wr_data[TEX_ADDR_BITS-1:0];
    img.logdims[0] = wr_data[TEX_LOD_BITS-1:0];
    img.logdims[1] = wr_data[16 +: TEX_LOD_BITS];
    img.format     = wr_data[TEX_FORMAT_BITS-1:0];
    img.filter     = wr_data[0];
    img.wraps[0]   = wr_data[TEX_WRAP_BITS-1:0];
    img.wraps[1]   = wr_data[16 +: TEX_WRAP_BITS];
    for (int l = 0; l < int'(TEX_NUM_LODS); l++) begin
      img.mipoff[l] = wr_data[TEX_MIPOFF_BITS-1:0];
    end

    if (w_hit) begin
      if (w_off32 == TEX_DCR_STAGE) begin
        if (wr_data < NUM_STAGES) begin
          stage_we  = 1'b1;
          stage_val = wr_data[STAGE_W-1:0];
        end
      end
      if (w_off32 == TEX_DCR_ADDR)   field_we[TEX_FWE_ADDR]   = 1'b1;
      if (w_off32 == TEX_DCR_LOGDIM) field_we[TEX_FWE_LOGDIM] = 1'b1;
      if (w_off32 == TEX_DCR_FORMAT) field_we[TEX_FWE_FORMAT] = 1'b1;
      if (w_off32 == TEX_DCR_FILTER) field_we[TEX_FWE_FILTER] = 1'b1;
      if (w_off32 == TEX_DCR_WRAP)   field_we[TEX_FWE_WRAP]   = 1'b1;
      for (int l = 0; l < int'(TEX_NUM_LODS); l++) begin
        if (w_off32 == TEX_DCR_MIPOFF + 32'(l)) field_we[TEX_FWE_MIPOFF + l] = 1'b1;
      end
`ifdef TEX_DCR_SHADOW_EN
      if (w_off32 == TEX_DCR_COMMIT) commit = 1'b1;
`endif
    end
  end

endmodule
`default_nettype wire

// File: rtl/tex_dcr_bank.sv
`default_nettype none
// ============================================================================
// Module   : tex_dcr_bank
// Brief    : Per-stage texture DCR store with a registered 1-cycle lookup port.
//            Macro TEX_DCR_SHADOW_EN: writes land in shadow state, published by COMMIT.
// Revision : 1.0  initial release
// ============================================================================
module tex_dcr_bank
  import VX_tex_types::*;
#(
  parameter int unsigned       NUM_STAGES = 2,
  parameter int unsigned       ADDR_W     = 12,
  parameter logic [ADDR_W-1:0] DCR_BASE   = '0
) (
  input  logic           clk,
  input  logic           reset_n,
  tex_dcr_bank_if.slave  bus
);

  localparam int unsigned STAGE_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic               w_stage_we;
  logic [STAGE_W-1:0] w_stage_val;
  tex_fwe_t           w_field_we;
  tex_dcrs_t          w_img;
  tex_dcrs_t          w_rd;
  logic               w_accept;

  logic [STAGE_W-1:0] r_sel_stage;
  tex_dcrs_t          r_live [NUM_STAGES];
  logic               r_rsp_valid;
  tex_dcrs_t          r_rsp_dcrs;

`ifdef TEX_DCR_SHADOW_EN
  logic               w_commit;
  tex_dcrs_t          r_shadow [NUM_STAGES];
`endif

  tex_dcr_decode #(
    .NUM_STAGES (NUM_STAGES),
    .STAGE_W    (STAGE_W),
    .ADDR_W     (ADDR_W),
    .DCR_BASE   (DCR_BASE)
  ) u_decode (
    .wr_valid  (bus.dcr_wr_valid),
    .wr_addr   (bus.dcr_wr_addr),
    .wr_data   (bus.dcr_wr_data),
    .stage_we  (w_stage_we),
    .stage_val (w_stage_val),
    .field_we  (w_field_we),
`ifdef TEX_DCR_SHADOW_EN
    .commit    (w_commit),
`endif
    .img       (w_img)
  );

  // Field writes and commits target the stage selected before this edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sel_stage <= '0;
      for (int s = 0; s < int'(NUM_STAGES); s++) begin
        r_live[s]   <= '0;
`ifdef TEX_DCR_SHADOW_EN
        r_shadow[s] <= '0;
`endif
      end
    end else begin
      if (w_stage_we) r_sel_stage <= w_stage_val;
      for (int s = 0; s < int'(NUM_STAGES); s++) begin
        if (32'(r_sel_stage) == 32'(s)) begin
`ifdef TEX_DCR_SHADOW_EN
          r_shadow[s] <= tex_dcr_merge(r_shadow[s], w_img, w_field_we);
          if (w_commit) r_live[s] <= r_shadow[s];
`else
          r_live[s] <= tex_dcr_merge(r_live[s], w_img, w_field_we);
`endif
        end
      end
    end
  end

  // Out-of-range stage indices match no entry and read back as zero.
  always_comb begin
    w_rd = '0;
    for (int s = 0; s < int'(NUM_STAGES); s++) begin
      if (32'(bus.req_stage) == 32'(s)) w_rd = r_live[s];
    end
  end

  assign bus.req_ready = !r_rsp_valid || bus.rsp_ready;
  assign w_accept      = bus.req_valid && bus.req_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_dcrs  <= '0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_dcrs  <= w_rd;
    end else if (bus.rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_dcrs  = r_rsp_dcrs;

endmodule
`default_nettype wire

// File: tb/tb_tex_dcr_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_tex_dcr_bank
// Brief    : Scoreboard bench for tex_dcr_bank; honours TEX_DCR_SHADOW_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_tex_dcr_bank;
  import VX_tex_types::*;

  localparam int unsigned      NS   = 3;
  localparam int unsigned      AW   = 12;
  localparam int unsigned      SW   = 2;
  localparam logic [AW-1:0]    BASE = 12'h100;
`ifdef TEX_DCR_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  tex_dcrs_t sb [$];
  tex_dcrs_t m_live   [NS];
  tex_dcrs_t m_shadow [NS];
  int        m_sel;

  tex_dcr_bank_if #(.ADDR_W(AW), .STAGE_W(SW)) bus ();

  tex_dcr_bank #(.NUM_STAGES(NS), .ADDR_W(AW), .DCR_BASE(BASE)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic void mdl_reset();
    for (int s = 0; s < int'(NS); s++) begin
      m_live[s]   = '0;
      m_shadow[s] = '0;
    end
    m_sel = 0;
  endfunction

  function automatic void mdl_write(logic [AW-1:0] off, logic [31:0] d);
    int unsigned o;
    tex_dcrs_t   t;
    o = 32'(off);
    t = SHADOW ? m_shadow[m_sel] : m_live[m_sel];
    if (o == TEX_DCR_STAGE) begin
      if (d < NS) m_sel = int'(d);
    end else if (o == TEX_DCR_COMMIT) begin
      if (SHADOW) m_live[m_sel] = m_shadow[m_sel];
    end else begin
      if (o == TEX_DCR_ADDR) t.baseaddr = d[TEX_ADDR_BITS-1:0];
      if (o == TEX_DCR_LOGDIM) begin
        t.logdims[0] = d[3:0];
        t.logdims[1] = d[19:16];
      end
      if (o == TEX_DCR_FORMAT) t.format = d[2:0];
      if (o == TEX_DCR_FILTER) t.filter = d[0];
      if (o == TEX_DCR_WRAP) begin
        t.wraps[0] = d[1:0];
        t.wraps[1] = d[17:16];
      end
      for (int l = 0; l < int'(TEX_NUM_LODS); l++) begin
        if (o == TEX_DCR_MIPOFF + 32'(l)) t.mipoff[l] = d[TEX_MIPOFF_BITS-1:0];
      end
      if (SHADOW) m_shadow[m_sel] = t;
      else        m_live[m_sel]   = t;
    end
  endfunction

  task automatic set_write(logic [AW-1:0] off, logic [31:0] d);
    bus.dcr_wr_valid = 1'b1;
    bus.dcr_wr_addr  = BASE + off;
    bus.dcr_wr_data  = d;
    mdl_write(off, d);
  endtask

  task automatic clr_write();
    bus.dcr_wr_valid = 1'b0;
  endtask

  task automatic dcr_write(logic [AW-1:0] off, logic [31:0] d);
    set_write(off, d);
    cyc();
    clr_write();
  endtask

  // Expected value is taken from the model before any same-cycle write is applied.
  task automatic issue(int s);
    logic [31:0] sv;
    sv = 32'(s);
    bus.req_valid = 1'b1;
    bus.req_stage = sv[SW-1:0];
    if (s < int'(NS)) sb.push_back(m_live[s]);
    else              sb.push_back('0);
  endtask

  task automatic test_reset();
    tex_dcrs_t exp;
    bus.dcr_wr_valid = 1'b0;
    bus.dcr_wr_addr  = '0;
    bus.dcr_wr_data  = '0;
    bus.req_valid    = 1'b0;
    bus.req_stage    = '0;
    bus.rsp_ready    = 1'b1;
    reset_n = 1'b0;
    mdl_reset();
    sb.delete();
    cyc(); cyc();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    checks++;
    if (bus.rsp_dcrs !== '0) begin errors++; $display("FAIL reset_rsp_dcrs: got %h want 0", bus.rsp_dcrs); end
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
    reset_n = 1'b1;
    cyc();
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_req_ready: got %b want 1", bus.req_ready); end
    issue(0);
    cyc();
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      errors++; $display("FAIL reset_lookup_valid: got %b want 1", bus.rsp_valid); void'(sb.pop_front());
    end else begin
      exp = sb.pop_front(); checks++;
      if (bus.rsp_dcrs !== exp) begin errors++; $display("FAIL reset_lookup_data: got %h want %h", bus.rsp_dcrs, exp); end
    end
    bus.req_valid = 1'b0;
    cyc();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid: got %b want 0", bus.rsp_valid); end
  endtask

  task automatic test_write_read();
    tex_dcrs_t exp, k;
    dcr_write(TEX_DCR_STAGE[AW-1:0], 32'd1);
    dcr_write(TEX_DCR_ADDR[AW-1:0], 32'h0123456);
    dcr_write(TEX_DCR_LOGDIM[AW-1:0], 32'h0009_000A);
    dcr_write(TEX_DCR_WRAP[AW-1:0], 32'h0002_0001);
    dcr_write(12'(TEX_DCR_MIPOFF + TEX_LOD_MAX), 32'h155);
    dcr_write(TEX_DCR_COMMIT[AW-1:0], 32'h0);
    k = '0;
    k.baseaddr   = 28'h0123456;
    k.logdims[1] = 4'd9;
    k.logdims[0] = 4'd10;
    k.wraps[1]   = 2'd2;
    k.wraps[0]   = 2'd1;
    k.mipoff[TEX_LOD_MAX] = 20'h155;
    bus.req_valid = 1'b1;
    bus.req_stage = 2'd1;
    sb.push_back(k);
    cyc();
    bus.req_stage = 2'd0;
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      errors++; $display("FAIL wr_stage1_valid: got %b want 1", bus.rsp_valid); void'(sb.pop_front());
    end else begin
      exp = sb.pop_front(); checks++;
      if (bus.rsp_dcrs !== exp) begin errors++; $display("FAIL wr_stage1_data: got %h want %h", bus.rsp_dcrs, exp); end
    end
    sb.push_back('0);
    cyc();
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      errors++; $display("FAIL wr_stage0_valid: got %b want 1", bus.rsp_valid); void'(sb.pop_front());
    end else begin
      exp = sb.pop_front(); checks++;
      if (bus.rsp_dcrs !== exp) begin errors++; $display("FAIL wr_stage0_data: got %h want %h", bus.rsp_dcrs, exp); end
    end
    bus.req_valid = 1'b0;
    cyc();
  endtask

  task automatic test_backpressure();
    tex_dcrs_t exp;
    bus.rsp_ready = 1'b0;
    issue(1);
    cyc();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0)
        begin errors++; $display("FAIL bp_stall_%0d: valid %b ready %b want 1 0", i, bus.rsp_valid, bus.req_ready); end
      checks++;
      if (bus.rsp_dcrs !== sb[0]) begin errors++; $display("FAIL bp_hold_%0d: got %h want %h", i, bus.rsp_dcrs, sb[0]); end
      if (i == 0) set_write(TEX_DCR_FILTER[AW-1:0], 32'h1);
      else        clr_write();
      cyc();
    end
    checks++;
    if (bus.rsp_dcrs !== sb[0]) begin errors++; $display("FAIL bp_hold_final: got %h want %h", bus.rsp_dcrs, sb[0]); end
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", bus.req_ready); end
    void'(sb.pop_front());
    issue(1);
    cyc();
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      errors++; $display("FAIL bp_after1_valid: got %b want 1", bus.rsp_valid); void'(sb.pop_front());
    end else begin
      exp = sb.pop_front(); checks++;
      if (bus.rsp_dcrs !== exp) begin errors++; $display("FAIL bp_after1_data: got %h want %h", bus.rsp_dcrs, exp); end
    end
    issue(0);
    cyc();
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      errors++; $display("FAIL bp_after2_valid: got %b want 1", bus.rsp_valid); void'(sb.pop_front());
    end else begin
      exp = sb.pop_front(); checks++;
      if (bus.rsp_dcrs !== exp) begin errors++; $display("FAIL bp_after2_data: got %h want %h", bus.rsp_dcrs, exp); end
    end
    bus.req_valid = 1'b0;
    cyc();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drain_valid: got %b want 0", bus.rsp_valid); end
  endtask

  task automatic test_hazard();
    tex_dcrs_t exp;
    dcr_write(TEX_DCR_STAGE[AW-1:0], 32'd0);
    issue(0);
    set_write(TEX_DCR_FORMAT[AW-1:0], 32'h3);
    cyc();
    clr_write();
    bus.req_valid = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      errors++; $display("FAIL hz_first_valid: got %b want 1", bus.rsp_valid); void'(sb.pop_front());
    end else begin
      exp = sb.pop_front(); checks++;
      if (bus.rsp_dcrs !== exp || bus.rsp_dcrs.format !== 3'd0)
        begin errors++; $display("FAIL hz_first_data: got %h want %h", bus.rsp_dcrs, exp); end
    end
    dcr_write(TEX_DCR_COMMIT[AW-1:0], 32'h0);
    issue(0);
    cyc();
    bus.req_valid = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      errors++; $display("FAIL hz_next_valid: got %b want 1", bus.rsp_valid); void'(sb.pop_front());
    end else begin
      exp = sb.pop_front(); checks++;
      if (bus.rsp_dcrs !== exp || bus.rsp_dcrs.format !== 3'd3)
        begin errors++; $display("FAIL hz_next_data: got %h want %h", bus.rsp_dcrs, exp); end
    end
    cyc();
  endtask

  task automatic test_illegal();
    tex_dcrs_t exp;
    dcr_write(TEX_DCR_STAGE[AW-1:0], 32'd0);
    dcr_write(TEX_DCR_STAGE[AW-1:0], 32'(NS));
    dcr_write(TEX_DCR_ADDR[AW-1:0], 32'hFFFF_FFFF);
    dcr_write(12'(TEX_DCR_MIPOFF + TEX_LOD_MAX + 2), 32'hFFFF_FFFF);
    dcr_write(12'hFFF, 32'hFFFF_FFFF);
    dcr_write(TEX_DCR_COMMIT[AW-1:0], 32'h0);
    for (int s = 0; s < 4; s++) begin
      issue(s);
      cyc();
      checks++;
      if (bus.rsp_valid !== 1'b1) begin
        errors++; $display("FAIL il_stage%0d_valid: got %b want 1", s, bus.rsp_valid); void'(sb.pop_front());
      end else begin
        exp = sb.pop_front(); checks++;
        if (bus.rsp_dcrs !== exp) begin errors++; $display("FAIL il_stage%0d_data: got %h want %h", s, bus.rsp_dcrs, exp); end
        if (s == 0) begin
          checks++;
          if (bus.rsp_dcrs.baseaddr !== 28'hFFF_FFFF)
            begin errors++; $display("FAIL il_stage0_addr: got %h want fffffff", bus.rsp_dcrs.baseaddr); end
        end
      end
    end
    bus.req_valid = 1'b0;
    cyc();
  endtask

`ifdef TEX_DCR_SHADOW_EN
  task automatic test_shadow();
    tex_dcrs_t exp;
    dcr_write(TEX_DCR_STAGE[AW-1:0], 32'd2);
    dcr_write(TEX_DCR_ADDR[AW-1:0], 32'h10);
    issue(2);
    cyc();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_dcrs.baseaddr !== 28'h0)
      begin errors++; $display("FAIL sh_nocommit: valid %b addr %h want 1 0", bus.rsp_valid, bus.rsp_dcrs.baseaddr); end
    exp = sb.pop_front();
    checks++;
    if (bus.rsp_dcrs !== exp) begin errors++; $display("FAIL sh_nocommit_data: got %h want %h", bus.rsp_dcrs, exp); end
    issue(2);
    set_write(TEX_DCR_COMMIT[AW-1:0], 32'hDEAD_BEEF);
    cyc();
    clr_write();
    exp = sb.pop_front();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_dcrs !== exp)
      begin errors++; $display("FAIL sh_commit_same_cycle: got %h want %h", bus.rsp_dcrs, exp); end
    issue(2);
    cyc();
    bus.req_valid = 1'b0;
    exp = sb.pop_front();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_dcrs.baseaddr !== 28'h10 || bus.rsp_dcrs !== exp)
      begin errors++; $display("FAIL sh_after_commit: got %h want %h", bus.rsp_dcrs, exp); end
    cyc();
  endtask
`endif

  task automatic test_reset_midstall();
    tex_dcrs_t exp;
    bus.rsp_ready = 1'b0;
    issue(1);
    cyc();
    checks++;
    if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL rs_stall_valid: got %b want 1", bus.rsp_valid); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_dcrs !== '0)
      begin errors++; $display("FAIL rs_async_drop: valid %b data %h want 0 0", bus.rsp_valid, bus.rsp_dcrs); end
    sb.delete();
    mdl_reset();
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    cyc();
    reset_n = 1'b1;
    cyc();
    issue(1);
    cyc();
    bus.req_valid = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      errors++; $display("FAIL rs_cleared_valid: got %b want 1", bus.rsp_valid); void'(sb.pop_front());
    end else begin
      exp = sb.pop_front(); checks++;
      if (bus.rsp_dcrs !== exp) begin errors++; $display("FAIL rs_cleared_data: got %h want %h", bus.rsp_dcrs, exp); end
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_backpressure();
    test_hazard();
    test_illegal();
`ifdef TEX_DCR_SHADOW_EN
    test_shadow();
`endif
    test_reset_midstall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
